// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the prefetching fetch stage: state encoding,
// queue entry layout and J-type immediate decode.
package fetch_prefetch_pkg;

  typedef logic [31:0]        addr_t;
  typedef logic signed [31:0] imm_t;
  typedef logic [31:0]        inst_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_RUN   = 2'd1;
  localparam fetch_state_t ST_FLUSH = 2'd2;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
    logic  pred;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_jal(input inst_t i);
    return i[6:0] == OPCODE_JAL;
  endfunction

  function automatic imm_t jal_imm(input inst_t i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirect)
// and decode. master = fetch stage, slave = its environment.
interface fetch_prefetch_if;
  import fetch_prefetch_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  addr_t imem_req_addr;
  logic  imem_rsp_valid;
  inst_t imem_rsp_data;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst_data;
  addr_t inst_pc;
  logic  inst_pred_taken;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, inst_pred_taken,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, inst_pred_taken,
    output inst_ready
  );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO with push/pop/clear; used for the instruction queue and the
// in-flight request-address queue. Storage is not reset, only pointers/count.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: in-order imem requests, DEPTH-entry instruction queue,
// redirect flush with stale-response discard. FETCH_JAL_PRED_EN enables JAL prediction.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int    DEPTH     = 4,
  parameter int    MAX_OUTST = 2,
  parameter addr_t RESET_PC  = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  fetch_prefetch_if.master bus
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  addr_t        r_fpc;
  addr_t        w_fpc_nxt;
  logic [OCW-1:0] r_stale;
  logic [OCW-1:0] w_stale_nxt;
  logic [OCW-1:0] w_outst;
  logic [OCW-1:0] w_outst_nxt;

  logic         w_req_hs;
  logic         w_rsp;
  logic         w_push;
  logic         w_pop;
  logic         w_jal_hit;
  logic         w_redir;
  addr_t        w_redir_pc;
  addr_t        w_a_head;
  logic         w_a_full;
  logic         w_a_empty;
  fetch_entry_t w_q_wdata;
  fetch_entry_t w_q_rdata;
  logic [QCW-1:0] w_q_count;
  logic         w_q_full;
  logic         w_q_empty;

  // Address queue depth equals the outstanding-request count.
  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_addr_q (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_push  (w_req_hs),
    .i_pop   (w_rsp),
    .i_wdata (r_fpc),
    .o_rdata (w_a_head),
    .o_count (w_outst),
    .o_full  (w_a_full),
    .o_empty (w_a_empty)
  );

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .reset   (reset),
    .i_clear (bus.redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_q_wdata),
    .o_rdata (w_q_rdata),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign bus.imem_req_valid = (r_state != ST_IDLE) && !bus.redirect_valid && !w_a_full &&
                              ((int'(w_q_count) + int'(w_outst)) < DEPTH);
  assign bus.imem_req_addr  = r_fpc;

  assign w_req_hs = bus.imem_req_valid && bus.imem_req_ready;
  assign w_rsp    = bus.imem_rsp_valid;
  assign w_pop    = bus.inst_valid && bus.inst_ready;
  // A response in a redirect cycle belongs to the old path and is dropped.
  assign w_push   = w_rsp && (r_stale == '0) && !bus.redirect_valid;

`ifdef FETCH_JAL_PRED_EN
  assign w_jal_hit = w_push && is_jal(bus.imem_rsp_data);
`else
  assign w_jal_hit = 1'b0;
`endif

  assign w_q_wdata = '{inst: bus.imem_rsp_data, pc: w_a_head, pred: w_jal_hit};

  always_comb begin
    w_redir    = bus.redirect_valid;
    w_redir_pc = bus.redirect_pc;
`ifdef FETCH_JAL_PRED_EN
    if (!bus.redirect_valid && w_jal_hit) begin
      w_redir    = 1'b1;
      w_redir_pc = w_a_head + addr_t'(jal_imm(bus.imem_rsp_data));
    end
`endif
  end

  assign w_outst_nxt = w_outst + OCW'(w_req_hs) - OCW'(w_rsp);

  always_comb begin
    w_stale_nxt = r_stale;
    if (w_rsp && (r_stale != '0)) w_stale_nxt = r_stale - OCW'(1);
    // Everything still in flight after this edge was fetched down the old path.
    if (w_redir) w_stale_nxt = w_outst_nxt;
  end

  always_comb begin
    w_fpc_nxt = r_fpc;
    if (w_req_hs) w_fpc_nxt = r_fpc + 32'd4;
    if (w_redir)  w_fpc_nxt = w_redir_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_redir && (w_stale_nxt != '0)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_stale_nxt == '0) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fpc   <= RESET_PC;
      r_stale <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  assign bus.inst_valid      = !w_q_empty;
  assign bus.inst_data       = w_q_empty ? '0 : w_q_rdata.inst;
  assign bus.inst_pc         = w_q_empty ? '0 : w_q_rdata.pc;
  assign bus.inst_pred_taken = !w_q_empty && w_q_rdata.pred;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && w_q_full && !w_pop));
      assert (!(w_rsp && w_a_empty));
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: reset, streaming, backpressure, redirects,
// PC wrap and JAL prediction against an in-order imem model.
module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fetch_prefetch_if ifc ();

  fetch_prefetch #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct { addr_t pc; inst_t data; logic pred; int cyc; } dlv_t;
  typedef struct { addr_t addr; int due; } pend_t;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    rsp_lat = 1;
  addr_t jal_addr = 32'h1;
  addr_t req_log[$];
  dlv_t  dlv[$];
  pend_t pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic inst_t mem_word(input addr_t a);
    if (a == jal_addr) return 32'h0100_006F;
    return {a[24:0], 7'h13};
  endfunction

  function automatic addr_t pc_at(input int i);
    return (i >= 0 && i < dlv.size()) ? dlv[i].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic addr_t req_at(input int i);
    return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    tick(3);
    req_log.delete();
    dlv.delete();
    reset = 1'b0;
  endtask

  // Memory response driver: in order, one per cycle, rsp_lat cycles after acceptance.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = '0;
    end
  end

  // Handshake sampler on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      pend.delete();
    end else begin
      if (ifc.imem_req_valid && ifc.imem_req_ready) begin
        pend.push_back('{addr: ifc.imem_req_addr, due: cyc + rsp_lat});
        req_log.push_back(ifc.imem_req_addr);
      end
      if (ifc.inst_valid && ifc.inst_ready)
        dlv.push_back('{pc: ifc.inst_pc, data: ifc.inst_data, pred: ifc.inst_pred_taken, cyc: cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sz;
    int rsz;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;

    // Reset state
    reset = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("rst_req_addr", ifc.imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
    check("rst_inst_data", ifc.inst_data, 32'h0);
    check("rst_inst_pc", ifc.inst_pc, 32'h0);
    check("rst_pred", 32'(ifc.inst_pred_taken), 32'd0);

    // 1: streaming
    do_reset();
    @(negedge clk);
    check("t1_idle_no_req", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    check("t1_first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    check("t1_first_req_addr", ifc.imem_req_addr, 32'h0);
    tick(12);
    check("t1_req0", req_at(0), 32'h0);
    check("t1_req1", req_at(1), 32'h4);
    check("t1_req2", req_at(2), 32'h8);
    check("t1_pc0", pc_at(0), 32'h0);
    check("t1_pc1", pc_at(1), 32'h4);
    check("t1_pc2", pc_at(2), 32'h8);
    check("t1_ndlv", 32'(dlv.size() >= 4), 32'd1);
    check("t1_data0", dlv[0].data, 32'h0000_0013);
    check("t1_data2", dlv[2].data, 32'h0000_0413);
    check("t1_back2back_a", 32'(dlv[1].cyc - dlv[0].cyc), 32'd1);
    check("t1_back2back_b", 32'(dlv[2].cyc - dlv[1].cyc), 32'd1);
    check("t1_back2back_c", 32'(dlv[3].cyc - dlv[2].cyc), 32'd1);

    // 2: decode stall fills the queue
    do_reset();
    ifc.inst_ready = 1'b0;
    tick(12);
    check("t2_nreq", 32'(req_log.size()), 32'd4);
    check("t2_req_valid_off", 32'(ifc.imem_req_valid), 32'd0);
    check("t2_inst_valid", 32'(ifc.inst_valid), 32'd1);
    check("t2_head_pc", ifc.inst_pc, 32'h0);
    check("t2_head_data", ifc.inst_data, 32'h0000_0013);
    ifc.inst_ready = 1'b1;
    tick(15);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_pc%0d", i), pc_at(i), 32'(4 * i));

    // 3: redirect with two requests in flight
    rsp_lat = 5;
    do_reset();
    for (int i = 0; i < 20 && req_log.size() < 2; i++) tick(1);
    check("t3_two_outst", 32'(req_log.size()), 32'd2);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    check("t3_req_withdrawn", 32'(ifc.imem_req_valid), 32'd0);
    tick(1);
    ifc.redirect_valid = 1'b0;
    check("t3_inst_valid_after", 32'(ifc.inst_valid), 32'd0);
    tick(30);
    check("t3_req_after", req_at(2), 32'h100);
    check("t3_pc0", pc_at(0), 32'h100);
    check("t3_pc1", pc_at(1), 32'h104);
    rsp_lat = 1;

    // 4: redirect coincident with a response and a pop
    do_reset();
    tick(10);
    sz = dlv.size();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    check("t4_pop_in_redir", 32'(ifc.inst_valid), 32'd1);
    check("t4_rsp_coincident", 32'(ifc.imem_rsp_valid), 32'd1);
    check("t4_req_withdrawn", 32'(ifc.imem_req_valid), 32'd0);
    tick(1);
    ifc.redirect_valid = 1'b0;
    check("t4_flushed", 32'(ifc.inst_valid), 32'd0);
    tick(10);
    check("t4_popped_pc", pc_at(sz), 32'(4 * sz));
    check("t4_next_pc", pc_at(sz + 1), 32'h200);
    check("t4_next_pc2", pc_at(sz + 2), 32'h204);

    // 5: PC wrap
    tick(3);
    rsz = req_log.size();
    sz  = dlv.size();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    ifc.redirect_valid = 1'b0;
    tick(10);
    check("t5_req_top", req_at(rsz), 32'hFFFF_FFFC);
    check("t5_req_wrap", req_at(rsz + 1), 32'h0);
    check("t5_pc_top", pc_at(sz + 1), 32'hFFFF_FFFC);
    check("t5_pc_wrap", pc_at(sz + 2), 32'h0);
    check("t5_pc_wrap2", pc_at(sz + 3), 32'h4);

    // 6: JAL +16 at 0x8
    jal_addr = 32'h8;
    do_reset();
    tick(15);
    check("t6_pc0", pc_at(0), 32'h0);
    check("t6_pc1", pc_at(1), 32'h4);
    check("t6_pc2", pc_at(2), 32'h8);
    check("t6_jal_data", dlv[2].data, 32'h0100_006F);
    check("t6_pred_plain", 32'(dlv[1].pred), 32'd0);
`ifdef FETCH_JAL_PRED_EN
    check("t6_pred_jal", 32'(dlv[2].pred), 32'd1);
    check("t6_pc3", pc_at(3), 32'h18);
    check("t6_pc4", pc_at(4), 32'h1C);
`else
    check("t6_pred_jal", 32'(dlv[2].pred), 32'd0);
    check("t6_pc3", pc_at(3), 32'hC);
    check("t6_pc4", pc_at(4), 32'h10);
`endif
    jal_addr = 32'h1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
